// File: rtl/seg7_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_driver
// Purpose  : Converts a sampled N-bit binary value to BCD with a sequential
//            double-dabble engine (N shift cycles). A free-running refresh
//            scanner then time-multiplexes the stored digits onto a
//            common-anode seven-segment display, with optional blanking of
//            leading zeros.
// Ports    : clk       - clock, rising edge
//            reset_n   - asynchronous active-low reset
//            value     - binary value, sampled when load is accepted
//            load      - one-cycle conversion request (ignored while busy)
//            busy      - high while a conversion is in progress
//            digit_en  - anode enables, active-low, one-hot-low, bit 0 = LSD
//            seg       - segments, active-low, {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_driver #(
  parameter int N              = 16,
  parameter int DIGITS         = 5,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_LZ       = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      value,
  input  logic              load,
  output logic              busy,
  output logic [DIGITS-1:0] digit_en,
  output logic [6:0]        seg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(REFRESH_CYCLES);

  localparam logic [CNT_W-1:0] C_CNT_INIT  = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(1);
  localparam logic [PRE_W-1:0] C_PRE_MAX   = PRE_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_MAX   = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       C_SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Converter state
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   disp_q,  disp_d;

  // Scanner state
  logic [PRE_W-1:0]   pre_q,   pre_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [DIGITS-1:0]  den_q,   den_d;
  logic [6:0]         seg_q,   seg_d;

  logic [BCD_W-1:0]   bcd_adj;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction on every nibble that is 5 or more, before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = C_CNT_INIT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // {bcd, shift} <<= 1 after correction.
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[N-1]};
        shift_d = {shift_q[N-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Refresh scanner. Uses disp_q (not disp_d), so a tick coinciding with the
  // DONE copy still shows the previous value.
  // --------------------------------------------------------------------------
  logic              tick;
  logic              all_zero;
  logic [DIGITS-1:0] blank_mask;
  logic [3:0]        cur_nib;
  logic              cur_blank;

  assign tick = (pre_q == C_PRE_MAX);

  // blank_mask[k] set when k > 0 and all nibbles at positions >= k are zero.
  always_comb begin
    all_zero   = 1'b1;
    blank_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero && (disp_q[4*k +: 4] == 4'd0);
      blank_mask[k] = all_zero && (BLANK_LZ != 0);
    end
  end

  always_comb begin
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    idx_d     = idx_q;
    den_d     = den_q;
    seg_d     = seg_q;
    cur_nib   = 4'd0;
    cur_blank = 1'b0;
    if (tick) begin
      idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) begin
          cur_nib   = disp_q[4*k +: 4];
          cur_blank = blank_mask[k];
        end
      end
      den_d = ~(DIGITS'(1) << idx_d);
      seg_d = cur_blank ? C_SEG_BLANK : seg_encode(cur_nib);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pre_q   <= '0;
      idx_q   <= C_IDX_MAX;
      den_q   <= '1;
      seg_q   <= C_SEG_BLANK;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      den_q   <= den_d;
      seg_q   <= seg_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign digit_en = den_q;
  assign seg      = seg_q;

endmodule
`default_nettype wire

// File: doc/seg7_display_driver.md
# seg7_display_driver

Consumes the binary count produced by the team's up-counter and drives a multiplexed, common-anode seven-segment display. A sequential double-dabble converter turns a sampled N-bit value into BCD over N cycles. A free-running refresh scanner then time-multiplexes the stored digits onto a shared segment bus. The block sits between the counter output and the board's display pins.

## Interface

**Parameters**

- `N`, 16 — width of the binary input value.
- `DIGITS`, 5 — number of display digits. Must satisfy 10^DIGITS > 2^N - 1 (16 bits needs 5).
- `REFRESH_CYCLES`, 50000 — clock cycles each digit stays lit. Must be ≥ 2.
- `BLANK_LZ`, 1 — 1 blanks leading zeros; 0 shows all digits.

**Ports**

- `clk`  in  1 — single clock; all state changes on the rising edge.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `value`  in  N — binary value to display, sampled on `load`.
- `load`  in  1 — one-cycle request to convert `value`.
- `busy`  out  1 — high while a conversion is in progress.
- `digit_en`  out  DIGITS — anode enables, active-low, one-hot-low; bit 0 is the least significant digit.
- `seg`  out  7 — segments, active-low, `{g,f,e,d,c,b,a}`.

## Operation

**Converter FSM: IDLE → SHIFT → DONE → IDLE**

- **IDLE**
  - When `load` is 1, capture `value` into a shift register and clear the BCD scratch register (4·DIGITS bits).
  - Set the bit counter to N and go to SHIFT.
- **SHIFT** (exactly N cycles)
  - Each cycle, every BCD nibble ≥ 5 has 3 added.
  - Then {BCD, shift} shifts left by 1.
  - The bit counter decrements. When it reaches 0, go to DONE.
- **DONE** (1 cycle)
  - Copy the scratch BCD into the display register atomically.
  - Return to IDLE.
- `load` is ignored in SHIFT and DONE. No queueing.
- `busy` = 1 in SHIFT and DONE.

**Refresh scanner**

- Runs continuously and independently of the converter.
- The prescaler counts 0 … REFRESH_CYCLES-1 and wraps. Its terminal count is a "tick".
- On a tick:
  - The digit index advances and wraps from DIGITS-1 to 0.
  - `digit_en` and `seg` are registered from the new index and the current display register.
- **Blanking:** digit k is blanked (`seg` = 7'h7F) when BLANK_LZ = 1, k > 0, and every nibble at positions ≥ k is 0. Digit 0 is never blanked.
- **Encoding (active-low):**
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - A nibble > 9 is unreachable; if it occurs, drive 7'h7F.

## Timing

**Reset values** (reset asserted):

- State IDLE, `busy` 0.
- Display register 0, digit index DIGITS-1 (so the first tick selects digit 0).
- Prescaler 0.
- `digit_en` all 1 (all off), `seg` 7'h7F.

**After reset release**

- The first tick occurs REFRESH_CYCLES cycles after reset deassertion.
- At that tick, `digit_en` = ~1 and `seg` = 7'h40.

**Conversion latency**

- `load` sampled high in cycle t: `busy` is 1 from t+1 through t+N+1.
- The display register is updated at the edge ending cycle t+N+1. `busy` is 0 in cycle t+N+2.
- Another load is accepted in cycle t+N+2.

**Display update**

- A new value appears on the pins at the next tick after the display register update.
- A tick in the same cycle as the DONE copy uses the old display register.

**Reset mid-conversion**

- Aborts immediately. The display register returns to 0; the partial result is discarded.

## Test plan

- **Reset:** hold `reset_n` = 0 for 3 cycles, REFRESH_CYCLES = 4 → `busy` = 0, `digit_en` = 5'b11111, `seg` = 7'h7F. Four cycles after release: `digit_en` = 5'b11110, `seg` = 7'h40.
- **Full scale:** `load` with `value` = 65535 → `busy` high for 17 cycles. Over the next 5 ticks, digits 0..4 show 5, 3, 5, 5, 6 (`seg` 12, 30, 12, 12, 02) with `digit_en` walking 11110 → 01111, then wrapping to 11110.
- **Leading-zero blanking:** `value` = 0, then `value` = 907 → digits 1..4 are blanked for 0. For 907, digits show 7, 0, 9 (78, 40, 10) and digits 3..4 show 7'h7F. With BLANK_LZ = 0, `value` = 907 shows 7'h40 on digits 3..4.
- **Load while busy:** `load` 1234, then `load` 4321 eight cycles later → the second request is ignored and the display shows 1234.
- **Reset during SHIFT:** `load` 500, assert `reset_n` = 0 at cycle 6 → `busy` drops asynchronously. After release the display shows 0, and a new `load` 42 converts correctly.
- **Boundary:** `value` = 10 and `value` = 9999 → 10 shows 0 and 1 with three digits blank; 9999 shows four 9s with digit 4 blank.
